// File: rtl/wb_tdpram32_pkg.sv
// Shared FSM encodings and Wishbone CTI constants for wb_tdpram32_slave.
// The BURST encoding only exists when WB_TDPRAM32_BURST_EN is defined.
package wb_tdpram32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
`ifdef WB_TDPRAM32_BURST_EN
        ST_BURST = 2'b10,
`endif
        ST_ACK   = 2'b01
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_tdpram32_slave.sv
// Wishbone slave onto the 32-bit port of the 64/32 true dual-port RAM.
// Incrementing bursts are built only with WB_TDPRAM32_BURST_EN defined.
module wb_tdpram32_slave
    import wb_tdpram32_pkg::*;
#(
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [2:0]            wb_cti_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  ram_we,
    output logic                  ram_rd,
    output logic [3:0]            ram_byte_en,
    output logic [ADDR_WIDTH:0]   ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    localparam int AW = ADDR_WIDTH + 1;

    state_e        state_q;
    logic          ack_q;
    logic          err_q;
    logic          rd_q;
    logic          req;
    logic          oor;
    logic          strobe;
    logic [AW-1:0] adr_word;
    logic [AW-1:0] addr;
    logic          unused;
`ifdef WB_TDPRAM32_BURST_EN
    logic [AW-1:0] cnt_q;
`endif

    assign req      = wb_cyc_i & wb_stb_i;
    assign adr_word = wb_adr_i[ADDR_WIDTH+2:2];
    assign oor      = |wb_adr_i[31:ADDR_WIDTH+3];
    assign unused   = ^{wb_adr_i[1:0], wb_cti_i};

    always_comb begin
        strobe = 1'b0;
        addr   = adr_word;
        unique case (state_q)
            ST_IDLE: strobe = req & ~oor;
`ifdef WB_TDPRAM32_BURST_EN
            // Beats stream at the counter; anything but INCR stops issuing.
            ST_BURST: begin
                strobe = req & (wb_cti_i == CTI_INCR);
                addr   = cnt_q;
            end
`endif
            default: strobe = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
`ifdef WB_TDPRAM32_BURST_EN
            cnt_q   <= '0;
`endif
        end else begin
            ack_q <= strobe;
            rd_q  <= strobe & ~wb_we_i;
            err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        err_q   <= oor;
                        state_q <= ST_ACK;
`ifdef WB_TDPRAM32_BURST_EN
                        if (!oor && wb_cti_i == CTI_INCR) begin
                            state_q <= ST_BURST;
                            cnt_q   <= adr_word + AW'(1);
                        end
`endif
                    end
                end
                ST_ACK: state_q <= ST_IDLE;
`ifdef WB_TDPRAM32_BURST_EN
                ST_BURST: begin
                    if (strobe) cnt_q <= cnt_q + AW'(1);
                    else state_q <= ST_IDLE;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ram_we      = rst_n & strobe & wb_we_i;
    assign ram_rd      = rst_n & strobe & ~wb_we_i;
    assign ram_byte_en = wb_sel_i;
    assign ram_addr    = addr;
    assign ram_wdata   = wb_dat_i;

    // A master that drops cyc no longer wants the pending response.
    assign wb_ack_o = ack_q & wb_cyc_i;
    assign wb_err_o = err_q & wb_cyc_i;
    assign wb_dat_o = (ack_q & rd_q & wb_cyc_i) ? ram_rdata : '0;

endmodule

// File: tb/tb_wb_tdpram32_slave.sv
// Self-checking bench for wb_tdpram32_slave with a behavioural RAM and
// a word-level reference memory; burst tests run with WB_TDPRAM32_BURST_EN.
module tb_wb_tdpram32_slave;

    localparam int AWP   = 13;
    localparam int AW    = AWP + 1;
    localparam int DEPTH = 1 << AW;
    localparam logic [2:0] C_CLASSIC = 3'b000;
    localparam logic [2:0] C_INCR    = 3'b010;
    localparam logic [2:0] C_EOB     = 3'b111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]    wb_sel_i;
    logic [31:0]   wb_adr_i, wb_dat_i;
    logic [2:0]    wb_cti_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o, wb_err_o;
    logic          ram_we, ram_rd;
    logic [3:0]    ram_byte_en;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    int tests = 0;
    int fails = 0;

    bit   [31:0] mem [DEPTH];
    logic [31:0] ref_mem [int];

    always #5 clk = ~clk;

    wb_tdpram32_slave #(.ADDR_WIDTH(AWP)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_cti_i(wb_cti_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o), .ram_we(ram_we), .ram_rd(ram_rd),
        .ram_byte_en(ram_byte_en), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // External RAM port B: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_byte_en[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        if (ram_rd) ram_rdata <= mem[ram_addr];
    end

    function automatic logic [31:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    function automatic void ref_wr(input int w, input logic [3:0] sel,
                                   input logic [31:0] d);
        logic [31:0] v = ref_rd(w);
        for (int b = 0; b < 4; b++)
            if (sel[b]) v[8*b +: 8] = d[8*b +: 8];
        ref_mem[w] = v;
    endfunction

    task automatic bus_idle;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = 0;
        wb_adr_i = 0; wb_dat_i = 0; wb_cti_i = C_CLASSIC;
    endtask

    // One single-beat transfer; returns what was seen on each cycle.
    task automatic wb_xfer(input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] dat,
                           input logic [2:0] cti,
                           output logic s_we, output logic s_rd,
                           output logic [AW-1:0] s_addr, output logic [3:0] s_be,
                           output logic early, output logic ack, output logic err,
                           output logic [31:0] rdat, output logic late_strobe,
                           output logic post);
        @(negedge clk);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_sel_i = sel;
        wb_adr_i = adr; wb_dat_i = dat; wb_cti_i = cti;
        #1;
        s_we = ram_we; s_rd = ram_rd; s_addr = ram_addr; s_be = ram_byte_en;
        early = wb_ack_o | wb_err_o;
        @(negedge clk);
        ack = wb_ack_o; err = wb_err_o; rdat = wb_dat_o;
        late_strobe = ram_we | ram_rd;
        bus_idle();
        @(negedge clk);
        post = wb_ack_o | wb_err_o;
    endtask

    task automatic test_reset;
        rst_n = 0;
        bus_idle();
        repeat (3) @(negedge clk);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_sel_i = 4'hF;
        #1;
        tests++;
        if ({wb_ack_o, wb_err_o, ram_we, ram_rd} !== 4'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 0000", {wb_ack_o, wb_err_o, ram_we, ram_rd});
        end
        tests++;
        if (wb_dat_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_dat: got %h want 0", wb_dat_o);
        end
        bus_idle();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        tests++;
        if ((wb_ack_o | wb_err_o) !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got ack/err high, want low");
        end
    endtask

    task automatic test_classic;
        logic sw, sr, ea, a, e, ls, p;
        logic [AW-1:0] sa;
        logic [3:0] be;
        logic [31:0] rd;
        wb_xfer(1, 4'hF, 32'h8, 32'hDEADBEEF, C_CLASSIC, sw, sr, sa, be, ea, a, e, rd, ls, p);
        ref_wr(2, 4'hF, 32'hDEADBEEF);
        tests++;
        if ({sw, sr, sa, ea, a, e, ls, p} !== {2'b10, AW'(2), 5'b01000}) begin
            fails++;
            $display("FAIL classic_write: got we=%b rd=%b addr=%0d early=%b ack=%b err=%b late=%b post=%b want we=1 rd=0 addr=2 ack=1 others 0",
                     sw, sr, sa, ea, a, e, ls, p);
        end
        wb_xfer(0, 4'hF, 32'h8, 32'h0, C_CLASSIC, sw, sr, sa, be, ea, a, e, rd, ls, p);
        tests++;
        if ({sw, sr, sa, ea, a, e, ls, p} !== {2'b01, AW'(2), 5'b01000}) begin
            fails++;
            $display("FAIL classic_read_ctrl: got we=%b rd=%b addr=%0d early=%b ack=%b err=%b late=%b post=%b want rd=1 addr=2 ack=1",
                     sw, sr, sa, ea, a, e, ls, p);
        end
        tests++;
        if (rd !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL classic_read_data: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_byte_lane;
        logic sw, sr, ea, a, e, ls, p;
        logic [AW-1:0] sa;
        logic [3:0] be;
        logic [31:0] rd;
        wb_xfer(1, 4'hF, 32'h4, 32'hFFFFFFFF, C_CLASSIC, sw, sr, sa, be, ea, a, e, rd, ls, p);
        ref_wr(1, 4'hF, 32'hFFFFFFFF);
        wb_xfer(1, 4'b0010, 32'h4, 32'h11223344, C_CLASSIC, sw, sr, sa, be, ea, a, e, rd, ls, p);
        ref_wr(1, 4'b0010, 32'h11223344);
        tests++;
        if (be !== 4'b0010 || a !== 1'b1) begin
            fails++;
            $display("FAIL byte_lane_write: got be=%b ack=%b want be=0010 ack=1", be, a);
        end
        wb_xfer(0, 4'hF, 32'h4, 32'h0, C_CLASSIC, sw, sr, sa, be, ea, a, e, rd, ls, p);
        tests++;
        if (rd !== 32'hFFFF33FF || a !== 1'b1) begin
            fails++;
            $display("FAIL byte_lane_read: got %h ack=%b want ffff33ff ack=1", rd, a);
        end
        wb_xfer(1, 4'b0000, 32'h4, 32'h0, C_CLASSIC, sw, sr, sa, be, ea, a, e, rd, ls, p);
        tests++;
        if ({sw, be, a, e} !== 7'b1_0000_10) begin
            fails++;
            $display("FAIL sel_zero_write: got we=%b be=%b ack=%b err=%b want we=1 be=0000 ack=1 err=0",
                     sw, be, a, e);
        end
        wb_xfer(0, 4'hF, 32'h7, 32'h0, C_CLASSIC, sw, sr, sa, be, ea, a, e, rd, ls, p);
        tests++;
        if (rd !== ref_rd(1)) begin
            fails++;
            $display("FAIL sel_zero_read: got %h want %h", rd, ref_rd(1));
        end
    endtask

    task automatic test_out_of_range;
        logic sw, sr, ea, a, e, ls, p;
        logic [AW-1:0] sa;
        logic [3:0] be;
        logic [31:0] rd;
        logic [31:0] adrs [3];
        adrs[0] = 32'd1 << (AWP + 3);
        adrs[1] = 32'h8000_0008;
        adrs[2] = (32'd1 << (AWP + 3)) | 32'h4;
        for (int i = 0; i < 3; i++) begin
            wb_xfer(i[0] ? 1'b0 : 1'b1, 4'hF, adrs[i], 32'hA5A5A5A5, C_CLASSIC,
                    sw, sr, sa, be, ea, a, e, rd, ls, p);
            tests++;
            if ({sw, sr, ea, a, e, ls, p} !== 7'b0000100 || rd !== 32'h0) begin
                fails++;
                $display("FAIL oor_%0d: got we=%b rd=%b early=%b ack=%b err=%b late=%b post=%b dat=%h want err=1 only",
                         i, sw, sr, ea, a, e, ls, p, rd);
            end
        end
    endtask

    task automatic test_random;
        logic sw, sr, ea, a, e, ls, p;
        logic [AW-1:0] sa;
        logic [3:0] be;
        logic [31:0] rd, d;
        logic [3:0] sel;
        logic we;
        int w;
        for (int n = 0; n < 48; n++) begin
            w = $urandom_range(0, 1) ? int'($urandom_range(0, 7))
                                     : DEPTH - 1 - int'($urandom_range(0, 7));
            we  = 1'($urandom_range(0, 1));
            sel = 4'($urandom);
            d   = $urandom;
            wb_xfer(we, sel, 32'(w * 4) | 32'($urandom_range(0, 3)), d,
                    $urandom_range(0, 1) ? C_EOB : C_CLASSIC,
                    sw, sr, sa, be, ea, a, e, rd, ls, p);
            tests++;
            if ({sw, sr} !== {we, ~we} || sa !== AW'(w) || {ea, a, e, ls, p} !== 5'b01000) begin
                fails++;
                $display("FAIL rand_ctrl_%0d: got we=%b rd=%b addr=%0d ack=%b err=%b early=%b late=%b post=%b want we=%b addr=%0d ack=1",
                         n, sw, sr, sa, a, e, ea, ls, p, we, w);
            end
            if (we) ref_wr(w, sel, d);
            else begin
                tests++;
                if (rd !== ref_rd(w)) begin
                    fails++;
                    $display("FAIL rand_read_%0d: got %h want %h", n, rd, ref_rd(w));
                end
            end
        end
    endtask

    task automatic test_cyc_abort;
        logic sw, sr, ea, a, e, ls, p;
        logic [AW-1:0] sa;
        logic [3:0] be;
        logic [31:0] rd;
        @(negedge clk);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_sel_i = 4'hF;
        wb_adr_i = 32'h8; wb_cti_i = C_CLASSIC;
        #1;
        tests++;
        if (ram_rd !== 1'b1) begin
            fails++;
            $display("FAIL abort_strobe: got ram_rd=%b want 1", ram_rd);
        end
        @(posedge clk);
        #1;
        bus_idle();
        #1;
        tests++;
        if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
            fails++;
            $display("FAIL abort_ack: got ack=%b dat=%h want ack=0 dat=0", wb_ack_o, wb_dat_o);
        end
        @(negedge clk);
        wb_xfer(0, 4'hF, 32'h8, 32'h0, C_CLASSIC, sw, sr, sa, be, ea, a, e, rd, ls, p);
        tests++;
        if (a !== 1'b1 || ea !== 1'b0 || rd !== ref_rd(2)) begin
            fails++;
            $display("FAIL abort_next: got ack=%b early=%b dat=%h want ack=1 early=0 dat=%h",
                     a, ea, rd, ref_rd(2));
        end
    endtask

`ifdef WB_TDPRAM32_BURST_EN
    task automatic test_burst;
        logic sw, sr, ea, a, e, ls, p;
        logic [AW-1:0] sa;
        logic [3:0] be;
        logic [31:0] rd, d;
        int st = DEPTH - 1;
        for (int k = 0; k < 4; k++) begin
            d = $urandom;
            wb_xfer(1, 4'hF, 32'(((st + k) % DEPTH) * 4), d, C_CLASSIC,
                    sw, sr, sa, be, ea, a, e, rd, ls, p);
            ref_wr((st + k) % DEPTH, 4'hF, d);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 5) begin
                wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_sel_i = 4'hF;
                wb_adr_i = 32'(((st + (c == 0 ? 0 : c - 1)) % DEPTH) * 4);
                wb_cti_i = (c == 4) ? C_EOB : C_INCR;
            end else bus_idle();
            #1;
            tests++;
            if (c <= 3) begin
                if (ram_rd !== 1'b1 || ram_we !== 1'b0 || ram_addr !== AW'((st + c) % DEPTH)) begin
                    fails++;
                    $display("FAIL burst_addr_%0d: got rd=%b addr=%0d want rd=1 addr=%0d",
                             c, ram_rd, ram_addr, (st + c) % DEPTH);
                end
            end else if ((ram_rd | ram_we) !== 1'b0) begin
                fails++;
                $display("FAIL burst_strobe_%0d: got strobe high want low", c);
            end
            tests++;
            if (c >= 1 && c <= 4) begin
                if (wb_ack_o !== 1'b1 || wb_dat_o !== ref_rd((st + c - 1) % DEPTH)) begin
                    fails++;
                    $display("FAIL burst_ack_%0d: got ack=%b dat=%h want ack=1 dat=%h",
                             c, wb_ack_o, wb_dat_o, ref_rd((st + c - 1) % DEPTH));
                end
            end else if (wb_ack_o !== 1'b0) begin
                fails++;
                $display("FAIL burst_noack_%0d: got ack=1 want 0", c);
            end
        end
        wb_xfer(0, 4'hF, 32'h0, 32'h0, C_CLASSIC, sw, sr, sa, be, ea, a, e, rd, ls, p);
        tests++;
        if ({sr, ea, a, ls, p} !== 5'b10100 || rd !== ref_rd(0)) begin
            fails++;
            $display("FAIL burst_idle_after: got rd=%b ack=%b late=%b post=%b dat=%h want classic read of %h",
                     sr, a, ls, p, rd, ref_rd(0));
        end
    endtask
`else
    task automatic test_cti_as_classic;
        int strobes = 0;
        int acks = 0;
        @(negedge clk);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_sel_i = 4'hF;
        wb_adr_i = 32'h8; wb_cti_i = C_INCR;
        for (int c = 0; c < 4; c++) begin
            #1;
            strobes += int'(ram_rd);
            acks    += int'(wb_ack_o);
            @(negedge clk);
        end
        bus_idle();
        tests++;
        if (strobes != 2 || acks != 2) begin
            fails++;
            $display("FAIL incr_as_classic: got strobes=%0d acks=%0d want 2 and 2", strobes, acks);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid;
        logic sw, sr, ea, a, e, ls, p;
        logic [AW-1:0] sa;
        logic [3:0] be;
        logic [31:0] rd;
        int hits = 0;
        @(negedge clk);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_sel_i = 4'hF;
        wb_adr_i = 32'h10;
`ifdef WB_TDPRAM32_BURST_EN
        wb_cti_i = C_INCR;
        @(negedge clk);
        @(negedge clk);
        wb_adr_i = 32'h14;
`else
        wb_cti_i = C_CLASSIC;
        @(negedge clk);
`endif
        #1;
        tests++;
        if (wb_ack_o !== 1'b1) begin
            fails++;
            $display("FAIL midrst_pre: got ack=%b want 1", wb_ack_o);
        end
        rst_n = 0;
        #1;
        tests++;
        if ({wb_ack_o, ram_rd, ram_we} !== 3'b000) begin
            fails++;
            $display("FAIL midrst_drop: got ack/rd/we=%b want 000", {wb_ack_o, ram_rd, ram_we});
        end
        bus_idle();
        wb_cyc_i = 1;
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            hits += int'(wb_ack_o | wb_err_o);
        end
        bus_idle();
        tests++;
        if (hits != 0) begin
            fails++;
            $display("FAIL midrst_noack: got %0d responses want 0", hits);
        end
        wb_xfer(0, 4'hF, 32'h8, 32'h0, C_CLASSIC, sw, sr, sa, be, ea, a, e, rd, ls, p);
        tests++;
        if (a !== 1'b1 || sr !== 1'b1 || rd !== ref_rd(2)) begin
            fails++;
            $display("FAIL midrst_next: got rd=%b ack=%b dat=%h want rd=1 ack=1 dat=%h",
                     sr, a, rd, ref_rd(2));
        end
    endtask

    initial begin
        test_reset();
        test_classic();
        test_byte_lane();
        test_out_of_range();
        test_random();
        test_cyc_abort();
`ifdef WB_TDPRAM32_BURST_EN
        test_burst();
`else
        test_cti_as_classic();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
